// File: rtl/boolean_propose_scheduler.sv
// rtl/boolean_propose_scheduler.sv - boolean-phase proposal sequencer for the MCMC solver
// Picks a variable (round-robin or LFSR), drives the propose stage, waits for the evaluator, commits on accept.
module boolean_propose_scheduler #(
    parameter int          NUMBER_OF_BOOLEAN_VARIABLES         = 8,
    parameter int          BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX = 3,
    parameter int          ITERATION_WIDTH                     = 16,
    parameter logic [15:0] LFSR_SEED                           = 16'hACE1
) (
    input  logic                                           in_clk,
    input  logic                                           in_reset,
    input  logic                                           in_start,
    input  logic                                           in_mode,
    input  logic [ITERATION_WIDTH-1:0]                     in_num_iterations,
    input  logic [NUMBER_OF_BOOLEAN_VARIABLES-1:0]         in_initial_assignment,
    input  logic [NUMBER_OF_BOOLEAN_VARIABLES-1:0]         in_proposed_assignment,
    input  logic                                           in_eval_done,
    input  logic                                           in_accept,
    output logic                                           out_propose_enable,
    output logic [BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX-1:0] out_variable_index,
    output logic [NUMBER_OF_BOOLEAN_VARIABLES-1:0]         out_current_assignment,
    output logic                                           out_eval_valid,
    output logic [NUMBER_OF_BOOLEAN_VARIABLES-1:0]         out_eval_assignment,
    output logic                                           out_busy,
    output logic                                           out_done,
    output logic [ITERATION_WIDTH-1:0]                     out_iteration_count,
    output logic [ITERATION_WIDTH-1:0]                     out_accept_count
);

    localparam int W = BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX;
    localparam logic [W:0]   NUM_VARS   = (W+1)'(NUMBER_OF_BOOLEAN_VARIABLES);
    localparam logic [W-1:0] LAST_INDEX = W'(NUMBER_OF_BOOLEAN_VARIABLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_PROPOSE,
        S_EVAL_WAIT,
        S_COMMIT
    } state_t;

    state_t                     state;
    logic                       mode;
    logic [ITERATION_WIDTH-1:0] num_iterations;
    logic [W-1:0]               rr_pointer;
    logic [15:0]                lfsr;
    logic                       accept_q;

    // Candidate is taken from the LFSR value present in the SELECT cycle; the LFSR steps in that same cycle.
    logic                       lfsr_feedback;
    logic [W-1:0]               candidate;
    logic                       candidate_ok;
    logic [ITERATION_WIDTH-1:0] iteration_next;

    assign lfsr_feedback  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign candidate      = lfsr[W-1:0];
    assign candidate_ok   = {1'b0, candidate} < NUM_VARS;
    assign iteration_next = out_iteration_count + 1'b1;

    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            state                  <= S_IDLE;
            mode                   <= 1'b0;
            num_iterations         <= '0;
            rr_pointer             <= '0;
            lfsr                   <= LFSR_SEED;
            accept_q               <= 1'b0;
            out_propose_enable     <= 1'b0;
            out_variable_index     <= '0;
            out_current_assignment <= '0;
            out_eval_valid         <= 1'b0;
            out_eval_assignment    <= '0;
            out_busy               <= 1'b0;
            out_done               <= 1'b0;
            out_iteration_count    <= '0;
            out_accept_count       <= '0;
        end else begin
            out_propose_enable <= 1'b0;
            out_eval_valid     <= 1'b0;
            out_done           <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_start) begin
                        mode                   <= in_mode;
                        num_iterations         <= in_num_iterations;
                        out_current_assignment <= in_initial_assignment;
                        out_iteration_count    <= '0;
                        out_accept_count       <= '0;
                        if (in_num_iterations == '0) begin
                            out_done <= 1'b1;
                        end else begin
                            state    <= S_SELECT;
                            out_busy <= 1'b1;
                        end
                    end
                end
                S_SELECT: begin
                    if (!mode) begin
                        out_variable_index <= rr_pointer;
                        rr_pointer         <= (rr_pointer == LAST_INDEX) ? '0 : rr_pointer + 1'b1;
                        out_propose_enable <= 1'b1;
                        state              <= S_PROPOSE;
                    end else begin
                        lfsr <= {lfsr[14:0], lfsr_feedback};
                        if (candidate_ok) begin
                            out_variable_index <= candidate;
                            out_propose_enable <= 1'b1;
                            state              <= S_PROPOSE;
                        end
                    end
                end
                S_PROPOSE: begin
                    out_eval_assignment <= in_proposed_assignment;
                    out_eval_valid      <= 1'b1;
                    state               <= S_EVAL_WAIT;
                end
                S_EVAL_WAIT: begin
                    if (in_eval_done) begin
                        accept_q <= in_accept;
                        state    <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    if (accept_q) begin
                        out_current_assignment <= out_eval_assignment;
                        out_accept_count       <= out_accept_count + 1'b1;
                    end
                    out_iteration_count <= iteration_next;
                    if (iteration_next == num_iterations) begin
                        state    <= S_IDLE;
                        out_busy <= 1'b0;
                        out_done <= 1'b1;
                    end else begin
                        state <= S_SELECT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/boolean_propose_scheduler.md
Name: boolean_propose_scheduler

Overview:
- Sequences the boolean proposal datapath for the MCMC solver's boolean phase.
- Each iteration it selects a variable index (round-robin or LFSR-random), enables the combinational boolean propose stage, and hands the proposed assignment to the evaluation/acceptance unit.
- It commits the proposal only on accept, and repeats for a programmed number of iterations.
- Sits between the top-level solver control and the boolean propose/evaluate datapath.

Parameters:
NUMBER_OF_BOOLEAN_VARIABLES, 8, number of boolean variables; legal range 2..256
BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX, 3, width of variable index; must equal ceil(log2(NUMBER_OF_BOOLEAN_VARIABLES))
ITERATION_WIDTH, 16, width of iteration and accept counters
LFSR_SEED, 16'hACE1, nonzero reset value of the 16-bit LFSR

Ports:
in_clk  input  1  clock, all state on rising edge
in_reset  input  1  asynchronous active-high reset
in_start  input  1  single-cycle start pulse; sampled only in IDLE
in_mode  input  1  0 = round-robin index, 1 = LFSR-random index; sampled at start
in_num_iterations  input  ITERATION_WIDTH  proposals to run; sampled at start
in_initial_assignment  input  NUMBER_OF_BOOLEAN_VARIABLES  starting assignment; sampled at start
in_proposed_assignment  input  NUMBER_OF_BOOLEAN_VARIABLES  combinational output of propose stage
in_eval_done  input  1  evaluator result valid, single-cycle
in_accept  input  1  evaluator decision, qualified by in_eval_done
out_propose_enable  output  1  enable to propose stage
out_variable_index  output  BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX  variable to flip
out_current_assignment  output  NUMBER_OF_BOOLEAN_VARIABLES  committed assignment, feeds propose stage
out_eval_valid  output  1  single-cycle request to evaluator
out_eval_assignment  output  NUMBER_OF_BOOLEAN_VARIABLES  registered proposal under evaluation
out_busy  output  1  high in every state except IDLE
out_done  output  1  single-cycle completion pulse
out_iteration_count  output  ITERATION_WIDTH  proposals completed
out_accept_count  output  ITERATION_WIDTH  proposals accepted

Behaviour:
- Reset: the following outputs are 0: state=IDLE, out_propose_enable, out_variable_index, out_current_assignment, out_eval_valid, out_eval_assignment, out_busy, out_done, both counters, round-robin pointer. LFSR=LFSR_SEED. Reset mid-operation aborts to IDLE without a done pulse.
- FSM states: IDLE, SELECT, PROPOSE, EVAL_WAIT, COMMIT.
- IDLE:
  - in_start=1 latches mode, num_iterations and initial_assignment into out_current_assignment, and clears both counters.
  - If num_iterations=0, the block stays in IDLE and pulses out_done on the next cycle.
  - Otherwise it goes to SELECT.
  - in_start in any other state is ignored.
- SELECT, round-robin: index=pointer; pointer increments and wraps NUMBER_OF_BOOLEAN_VARIABLES-1 -> 0. Go to PROPOSE.
- SELECT, LFSR mode:
  - LFSR advances every SELECT cycle (Fibonacci, taps 16,14,13,11).
  - candidate = LFSR[BIT_WIDTH-1:0].
  - If candidate >= NUMBER_OF_BOOLEAN_VARIABLES, stay in SELECT and retry next cycle; else latch index and go to PROPOSE.
- PROPOSE: out_propose_enable=1 for exactly one cycle. Register in_proposed_assignment into out_eval_assignment, assert out_eval_valid for one cycle (next cycle), go to EVAL_WAIT.
- EVAL_WAIT:
  - Hold out_eval_assignment stable; wait unbounded for in_eval_done.
  - in_eval_done arriving in the same cycle out_eval_valid is high is legal and is accepted.
- COMMIT:
  - If accept, out_current_assignment <= out_eval_assignment and accept_count+1.
  - iteration_count+1.
  - If the new iteration_count equals num_iterations, go to IDLE with out_done=1 for one cycle; else go to SELECT.
- Minimum iteration latency in round-robin mode with in_eval_done returned one cycle after out_eval_valid: 5 cycles.
- out_propose_enable=0 outside PROPOSE, so the propose stage outputs all-zero when idle.
- Counters never wrap within a run, since num_iterations bounds them.
- out_variable_index holds its last value between iterations.

Test Plan:
- Round-robin, N=8, init 8'b0000_0000, 8 iterations, always accept -> out_current_assignment 8'b1111_1111, accept_count 8, iteration_count 8, done pulse once.
- Round-robin, 10 iterations, always reject -> assignment unchanged from init 8'hA5, accept_count 0, index sequence 0..7,0,1.
- LFSR mode with NUMBER_OF_BOOLEAN_VARIABLES=5 -> every out_variable_index <=4; out-of-range candidates add SELECT retry cycles; first index matches golden LFSR model from seed 16'hACE1.
- in_num_iterations=0 with start -> no out_propose_enable, out_done one cycle after start, busy stays 0.
- Reset asserted in EVAL_WAIT, async mid-cycle -> all outputs 0 immediately, no done pulse; new start then runs normally.
- in_start pulsed while busy, plus evaluator delaying in_eval_done 20 cycles -> start ignored, out_eval_assignment stable throughout wait, counts correct.
